// File: rtl/ascii_pkg.sv
// ----------------------------------------------------------------------------
// ascii_pkg
// Shared constants and types for the ASCII decimal parser (ascii_to_bin).
//   - ASCII character codes used by the parser
//   - parser state encoding
//   - character class encoding
//   - overflow limits, held 20 bits wide to match the multiply-accumulate path
// ----------------------------------------------------------------------------
package ascii_pkg;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SP    = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SIGN   = 2'd1,
        S_DIGITS = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CC_DIGIT   = 2'd0,
        CC_MINUS   = 2'd1,
        CC_TERM    = 2'd2,
        CC_ILLEGAL = 2'd3
    } char_class_t;

    localparam logic [19:0] U16_MAX     = 20'd65535;
    localparam logic [19:0] S16_POS_MAX = 20'd32767;
    localparam logic [19:0] S16_NEG_MAX = 20'd32768;

endpackage : ascii_pkg

// File: rtl/ascii_to_bin.sv
// ----------------------------------------------------------------------------
// ascii_to_bin
// Parses a decimal ASCII number, one byte per rx_valid strobe, into a 16-bit
// binary value. An optional leading '-' is accepted in signed mode; a token is
// closed by CR, LF or space. A good token produces a one-cycle done pulse with
// value updated; a bad token (malformed, overflow, too many digits, lone '-',
// or an inter-byte timeout) produces a one-cycle error pulse.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   clear        synchronous abort, discards the partial token, no pulse
//   is_signed    1: two's-complement result, '-' allowed; 0: unsigned
//   rx_valid     byte strobe, rx_data valid this cycle
//   rx_data      received ASCII byte
//   value        parsed result, updated only together with done
//   done         one-cycle pulse, value valid
//   error        one-cycle pulse, token rejected, value unchanged
//   busy         a token is in progress
//   digit_count  digits accepted in the current token
// ----------------------------------------------------------------------------
module ascii_to_bin
    import ascii_pkg::*;
#(
    parameter int MAX_DIGITS     = 5,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        is_signed,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [15:0] value,
    output logic        done,
    output logic        error,
    output logic        busy,
    output logic [2:0]  digit_count
);

    // The idle counter runs 0 .. TIMEOUT_CYCLES-1; the timeout fires on the
    // idle cycle that would take it to TIMEOUT_CYCLES.
    localparam int          TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [2:0]  MAX_DIG  = 3'(MAX_DIGITS);

    function automatic char_class_t classify(input logic [7:0] c);
        char_class_t cc;
        if (c >= ASCII_0 && c <= ASCII_9) begin
            cc = CC_DIGIT;
        end else if (c == ASCII_MINUS) begin
            cc = CC_MINUS;
        end else if (c == ASCII_CR || c == ASCII_LF || c == ASCII_SP) begin
            cc = CC_TERM;
        end else begin
            cc = CC_ILLEGAL;
        end
        return cc;
    endfunction

    state_t        state_q,  state_d;
    logic [15:0]   acc_q,    acc_d;
    logic          neg_q,    neg_d;
    logic          signed_q, signed_d;
    logic [2:0]    dcnt_q,   dcnt_d;
    logic [TW-1:0] tmo_q,    tmo_d;
    logic [15:0]   value_q,  value_d;
    logic          done_q,   done_d;
    logic          error_q,  error_d;

    char_class_t   cls;
    logic [19:0]   acc_next;
    logic [19:0]   limit;

    always_comb begin
        cls = classify(rx_data);

        // acc*10 + d without a multiplier; 20 bits covers 65535*10+9.
        acc_next = {1'b0, acc_q, 3'b000}
                 + {3'b000, acc_q, 1'b0}
                 + {16'd0, rx_data[3:0]};

        if (!signed_q) begin
            limit = U16_MAX;
        end else if (neg_q) begin
            limit = S16_NEG_MAX;
        end else begin
            limit = S16_POS_MAX;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        signed_d = signed_q;
        dcnt_d   = dcnt_q;
        tmo_d    = tmo_q;
        value_d  = value_q;
        done_d   = 1'b0;
        error_d  = 1'b0;

        if (clear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            neg_d   = 1'b0;
            dcnt_d  = '0;
            tmo_d   = '0;
        end else if (rx_valid) begin
            // A byte always wins over a timeout expiring in the same cycle.
            tmo_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (cls != CC_TERM) begin
                        signed_d = is_signed;
                    end
                    unique case (cls)
                        CC_DIGIT: begin
                            acc_d   = {12'd0, rx_data[3:0]};
                            dcnt_d  = 3'd1;
                            state_d = S_DIGITS;
                        end
                        CC_MINUS: begin
                            if (is_signed) begin
                                neg_d   = 1'b1;
                                state_d = S_SIGN;
                            end else begin
                                state_d = S_ERR;
                            end
                        end
                        CC_TERM: begin
                            // Stray terminators between tokens are ignored.
                        end
                        default: state_d = S_ERR;
                    endcase
                end

                S_SIGN: begin
                    unique case (cls)
                        CC_DIGIT: begin
                            acc_d   = {12'd0, rx_data[3:0]};
                            dcnt_d  = 3'd1;
                            state_d = S_DIGITS;
                        end
                        CC_TERM: begin
                            // A lone '-' is rejected immediately.
                            error_d = 1'b1;
                            state_d = S_IDLE;
                            acc_d   = '0;
                            neg_d   = 1'b0;
                            dcnt_d  = '0;
                        end
                        default: state_d = S_ERR;
                    endcase
                end

                S_DIGITS: begin
                    unique case (cls)
                        CC_DIGIT: begin
                            if (dcnt_q == MAX_DIG || acc_next > limit) begin
                                state_d = S_ERR;
                            end else begin
                                acc_d  = acc_next[15:0];
                                dcnt_d = dcnt_q + 3'd1;
                            end
                        end
                        CC_TERM: begin
                            done_d  = 1'b1;
                            value_d = neg_q ? (~acc_q + 16'd1) : acc_q;
                            state_d = S_IDLE;
                            acc_d   = '0;
                            neg_d   = 1'b0;
                            dcnt_d  = '0;
                        end
                        default: state_d = S_ERR;
                    endcase
                end

                default: begin
                    // S_ERR: swallow everything up to the terminator.
                    if (cls == CC_TERM) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                        acc_d   = '0;
                        neg_d   = 1'b0;
                        dcnt_d  = '0;
                    end
                end
            endcase
        end else if (TIMEOUT_CYCLES > 0 && state_q != S_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                error_d = 1'b1;
                state_d = S_IDLE;
                acc_d   = '0;
                neg_d   = 1'b0;
                dcnt_d  = '0;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            signed_q <= 1'b0;
            dcnt_q   <= '0;
            tmo_q    <= '0;
            value_q  <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            signed_q <= signed_d;
            dcnt_q   <= dcnt_d;
            tmo_q    <= tmo_d;
            value_q  <= value_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign value       = value_q;
    assign done        = done_q;
    assign error       = error_q;
    assign busy        = (state_q != S_IDLE);
    assign digit_count = dcnt_q;

endmodule : ascii_to_bin

// File: tb/tb_ascii_to_bin.sv
// ----------------------------------------------------------------------------
// tb_ascii_to_bin
// Self-checking bench for ascii_to_bin (MAX_DIGITS=5, TIMEOUT_CYCLES=8).
// Each cycle the outputs are compared on the falling edge against a token
// model that keeps the token text in a queue and judges it as a whole number
// when it closes. Directed scenarios come first, then random byte streams.
// ----------------------------------------------------------------------------
module tb_ascii_to_bin;

    localparam int MAXD = 5;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        is_signed;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [15:0] value;
    logic        done;
    logic        error;
    logic        busy;
    logic [2:0]  digit_count;

    ascii_to_bin #(
        .MAX_DIGITS     (MAXD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .is_signed   (is_signed),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .value       (value),
        .done        (done),
        .error       (error),
        .busy        (busy),
        .digit_count (digit_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;
    int err_seen  = 0;
    int cyc = 0;

    // Token model state
    logic [7:0]  tok[$];
    bit          in_tok;
    bit          tok_sgn;
    int          idle_cnt;
    logic        exp_done;
    logic        exp_error;
    logic [15:0] exp_value;
    logic        exp_busy;
    int          exp_dc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Judge a token as text: 0 = complete number, 1 = valid but no digits yet,
    // 2 = cannot become a valid number.
    function automatic int eval_tok(input logic [7:0] t[$], input bit sgn,
                                    output logic [15:0] v, output int nd);
        int  i   = 0;
        bit  neg = 1'b0;
        int  acc = 0;
        int  lim;
        v  = '0;
        nd = 0;
        if (t.size() > 0 && t[0] == 8'h2D && sgn) begin
            neg = 1'b1;
            i   = 1;
        end
        nd = t.size() - i;
        if (nd > MAXD) return 2;
        for (int k = i; k < t.size(); k++) begin
            if (t[k] < 8'h30 || t[k] > 8'h39) return 2;
            acc = acc * 10 + int'(t[k] - 8'h30);
        end
        lim = !sgn ? 65535 : (neg ? 32768 : 32767);
        if (acc > lim) return 2;
        v = neg ? 16'(-acc) : 16'(acc);
        return (nd == 0) ? 1 : 0;
    endfunction

    function automatic bit is_term(input logic [7:0] c);
        return (c == 8'h0D || c == 8'h0A || c == 8'h20);
    endfunction

    task automatic drop_token();
        tok.delete();
        in_tok   = 1'b0;
        idle_cnt = 0;
    endtask

    task automatic model(input bit v, input logic [7:0] d, input bit clr, input bit sgn);
        int          st;
        int          nd;
        logic [15:0] pv;
        exp_done  = 1'b0;
        exp_error = 1'b0;
        if (clr) begin
            drop_token();
        end else if (v) begin
            idle_cnt = 0;
            if (is_term(d)) begin
                if (in_tok) begin
                    st = eval_tok(tok, tok_sgn, pv, nd);
                    if (st == 0) begin
                        exp_done  = 1'b1;
                        exp_value = pv;
                    end else begin
                        exp_error = 1'b1;
                    end
                    drop_token();
                end
            end else begin
                if (!in_tok) begin
                    in_tok  = 1'b1;
                    tok_sgn = sgn;
                end
                tok.push_back(d);
            end
        end else if (in_tok) begin
            idle_cnt++;
            if (idle_cnt == TMO) begin
                exp_error = 1'b1;
                drop_token();
            end
        end
        exp_busy = in_tok;
        if (!in_tok) begin
            exp_dc = 0;
        end else begin
            st     = eval_tok(tok, tok_sgn, pv, nd);
            exp_dc = (st == 2) ? -1 : nd;
        end
    endtask

    task automatic check_outputs();
        chk("done", done, exp_done);
        chk("error", error, exp_error);
        chk("value", value, exp_value);
        chk("busy", busy, exp_busy);
        chk("done_and_error", done & error, 0);
        if (exp_dc >= 0) chk("digit_count", digit_count, exp_dc);
        if (done) begin
            done_seen++;
            $display("cycle %0d: token done, value=%04h", cyc, value);
        end
        if (error) begin
            err_seen++;
            $display("cycle %0d: token rejected, value held at %04h", cyc, value);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit clr, input bit sgn);
        @(negedge clk);
        cyc++;
        check_outputs();
        rx_valid  = v;
        rx_data   = d;
        clear     = clr;
        is_signed = sgn;
        model(v, d, clr, sgn);
    endtask

    task automatic idle(input int n, input bit sgn);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, sgn);
    endtask

    task automatic send(input string s, input bit sgn);
        for (int k = 0; k < s.len(); k++) step(1'b1, s[k], 1'b0, sgn);
    endtask

    task automatic run(input string s, input bit sgn);
        send(s, sgn);
        idle(1, sgn);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        check_outputs();
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        clear    = 1'b0;
        drop_token();
        exp_done  = 1'b0;
        exp_error = 1'b0;
        exp_value = '0;
        exp_busy  = 1'b0;
        exp_dc    = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] rand_byte();
        int r = $urandom_range(0, 99);
        logic [7:0] ill[5];
        logic [7:0] trm[3];
        ill[0] = 8'h61; ill[1] = 8'h2F; ill[2] = 8'h3A; ill[3] = 8'h00; ill[4] = 8'hFF;
        trm[0] = 8'h0D; trm[1] = 8'h0A; trm[2] = 8'h20;
        if (r < 62) return 8'h30 + 8'($urandom_range(0, 9));
        if (r < 82) return trm[$urandom_range(0, 2)];
        if (r < 91) return 8'h2D;
        return ill[$urandom_range(0, 4)];
    endfunction

    initial begin : main
        int d0;
        int e0;
        bit sgn;

        rst = 1'b1; clear = 1'b0; is_signed = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        exp_value = '0;
        drop_token();
        exp_done = 1'b0; exp_error = 1'b0; exp_busy = 1'b0; exp_dc = 0;
        repeat (3) @(posedge clk);
        do_reset();
        idle(1, 1'b0);
        chk("reset_value", value, 0);
        chk("reset_busy", busy, 0);

        // Unsigned 1234
        d0 = done_seen;
        run("1234", 1'b0);
        chk("dc_before_term", digit_count, 4);
        run("\r", 1'b0);
        chk("val_1234", value, 16'h04D2);
        chk("done_1234", done_seen - d0, 1);

        // Signed extremes
        run("-32768 ", 1'b1);
        chk("val_neg_min", value, 16'h8000);
        e0 = err_seen;
        run("32768 ", 1'b1);
        chk("err_pos_ovf", err_seen - e0, 1);
        chk("val_held_8000", value, 16'h8000);

        // Unsigned extremes and digit limit
        run("65535\n", 1'b0);
        chk("val_ffff", value, 16'hFFFF);
        e0 = err_seen;
        run("65536\n", 1'b0);
        run("000001\n", 1'b0);
        chk("err_ovf_and_len", err_seen - e0, 2);
        chk("val_held_ffff", value, 16'hFFFF);

        // Stray terminators and malformed tokens
        d0 = done_seen; e0 = err_seen;
        run("\r\n\r\n", 1'b0);
        chk("term_only_pulses", (done_seen - d0) + (err_seen - e0), 0);
        run("-\r", 1'b1);
        chk("err_lone_minus", err_seen - e0, 1);
        run("-5\r", 1'b0);
        chk("err_minus_unsigned", err_seen - e0, 2);
        run("1a2\r", 1'b0);
        chk("err_illegal", err_seen - e0, 3);

        // Inter-byte timeout
        e0 = err_seen; d0 = done_seen;
        send("12", 1'b0);
        idle(TMO + 2, 1'b0);
        chk("err_timeout", err_seen - e0, 1);
        chk("busy_after_tmo", busy, 0);
        run("7\r", 1'b0);
        chk("val_7", value, 16'h0007);
        chk("done_7", done_seen - d0, 1);

        // Clear drops the byte in its cycle and the partial token
        d0 = done_seen; e0 = err_seen;
        send("4", 1'b0);
        step(1'b1, 8'h35, 1'b1, 1'b0);
        idle(1, 1'b0);
        chk("busy_after_clear", busy, 0);
        run("\r", 1'b0);
        chk("clear_pulses", (done_seen - d0) + (err_seen - e0), 0);
        chk("val_after_clear", value, 16'h0007);

        // Minus zero
        run("-0 ", 1'b1);
        chk("val_minus_zero", value, 16'h0000);

        // Reset mid-token
        run("99 ", 1'b0);
        send("12", 1'b0);
        d0 = done_seen; e0 = err_seen;
        do_reset();
        run("\r", 1'b0);
        chk("reset_mid_pulses", (done_seen - d0) + (err_seen - e0), 0);
        chk("reset_mid_value", value, 0);

        // Random streams
        sgn = 1'b0;
        for (int it = 0; it < 3000; it++) begin
            int r = $urandom_range(0, 99);
            if ($urandom_range(0, 99) < 4) sgn = ~sgn;
            if (r < 2) begin
                step(1'b1, rand_byte(), 1'b1, sgn);
            end else if (r < 10) begin
                idle($urandom_range(1, 11), sgn);
            end else begin
                step(1'b1, rand_byte(), 1'b0, sgn);
            end
        end
        idle(TMO + 2, sgn);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ascii_to_bin
